// File: rtl/osr_controller_pkg.sv
// ---------------------------------------------------------------------------
// osr_controller_pkg
// Shared types for the OSR (output shift register) controller.
//
// Count encodings: both the OUT bit count and the autopull threshold are
// 5-bit fields where the value 0 stands for 32. decode32() expands such a
// field into a 6-bit unsigned value in the range 1..32.
// ---------------------------------------------------------------------------
package osr_controller_pkg;

    // Instruction class presented to the controller.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_OUT  = 2'd1,
        OP_PULL = 2'd2,
        OP_MOV  = 2'd3
    } osr_op_t;

    // Controller state.
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_OUT_WAIT  = 2'd1,
        S_PULL_WAIT = 2'd2
    } osr_state_t;

    // osr_count value meaning "OSR fully shifted out / empty".
    localparam logic [5:0] OSR_CNT_FULL = 6'd32;

    // 5-bit count field -> 6-bit count, with 0 encoding 32.
    function automatic logic [5:0] decode32(input logic [4:0] f);
        return (f == 5'd0) ? OSR_CNT_FULL : {1'b0, f};
    endfunction

endpackage

// File: rtl/osr_controller.sv
// ---------------------------------------------------------------------------
// osr_controller
// Sequences OUT / PULL / MOV instructions against the OSR and TX FIFO,
// including autopull and background refill. Sits beside the output shift
// register and drives its load / data_in / shift_en / shift_count.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid, instr_op         instruction present and its class
//   out_count                     OUT bit count (0 = 32)
//   pull_block, pull_ifempty      PULL modifiers
//   mov_data                      MOV source value
//   x_data                        scratch X (non-blocking PULL on empty FIFO)
//   autopull_en, pull_thresh      autopull config (threshold 0 = 32)
//   sm_restart                    clear controller state
//   fifo_empty, fifo_data         TX FIFO status / head word
//   fifo_pop                      pop FIFO head (only together with osr_load)
//   osr_load, osr_data            OSR load strobe and value
//   osr_shift_en, osr_shift_count OSR shift strobe and count (1..32)
//   instr_done                    instruction completes this cycle
//   stall                         instr_valid and not completing
//   osr_count                     bits shifted since last load (0..32)
// ---------------------------------------------------------------------------
module osr_controller
    import osr_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  osr_op_t     instr_op,
    input  logic [4:0]  out_count,
    input  logic        pull_block,
    input  logic        pull_ifempty,
    input  logic [31:0] mov_data,
    input  logic [31:0] x_data,
    input  logic        autopull_en,
    input  logic [4:0]  pull_thresh,
    input  logic        sm_restart,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_pop,
    output logic        osr_load,
    output logic [31:0] osr_data,
    output logic        osr_shift_en,
    output logic [5:0]  osr_shift_count,
    output logic        instr_done,
    output logic        stall,
    output logic [5:0]  osr_count
);

    osr_state_t state_q, state_d;
    logic [5:0] count_q, count_d;

    logic [5:0] thr;
    logic [5:0] n;
    logic [6:0] out_sum;
    logic       below_thr;
    logic       refill_due;

    assign thr        = decode32(pull_thresh);
    assign n          = decode32(out_count);
    assign out_sum    = {1'b0, count_q} + {1'b0, n};
    assign below_thr  = (count_q < thr);
    assign refill_due = autopull_en && !below_thr;

    assign osr_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            count_q <= OSR_CNT_FULL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        fifo_pop        = 1'b0;
        osr_load        = 1'b0;
        osr_data        = '0;
        osr_shift_en    = 1'b0;
        osr_shift_count = '0;
        instr_done      = 1'b0;

        if (rst || sm_restart) begin
            // Reset outputs are forced quiet below; restart forces the count
            // back to "empty" so the next OUT/idle cycle triggers a refill.
            state_d = S_RUN;
            count_d = OSR_CNT_FULL;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (instr_valid && instr_op == OP_OUT) begin
                        if (refill_due) begin
                            // Autopull first; the OUT itself retries next cycle.
                            if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                osr_load = 1'b1;
                                osr_data = fifo_data;
                                count_d  = '0;
                            end else begin
                                state_d = S_OUT_WAIT;
                            end
                        end else begin
                            osr_shift_en    = 1'b1;
                            osr_shift_count = n;
                            instr_done      = 1'b1;
                            count_d         = (out_sum > {1'b0, OSR_CNT_FULL}) ?
                                              OSR_CNT_FULL : out_sum[5:0];
                        end
                    end else if (instr_valid && instr_op == OP_PULL) begin
                        if (pull_ifempty && below_thr) begin
                            instr_done = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            osr_load   = 1'b1;
                            osr_data   = fifo_data;
                            count_d    = '0;
                            instr_done = 1'b1;
                        end else if (!pull_block) begin
                            osr_load   = 1'b1;
                            osr_data   = x_data;
                            count_d    = '0;
                            instr_done = 1'b1;
                        end else begin
                            state_d = S_PULL_WAIT;
                        end
                    end else if (instr_valid && instr_op == OP_MOV) begin
                        osr_load   = 1'b1;
                        osr_data   = mov_data;
                        count_d    = '0;
                        instr_done = 1'b1;
                    end else begin
                        // Idle or OP_NONE: background refill.
                        if (refill_due && !fifo_empty) begin
                            fifo_pop = 1'b1;
                            osr_load = 1'b1;
                            osr_data = fifo_data;
                            count_d  = '0;
                        end
                    end
                end

                S_OUT_WAIT: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        osr_load = 1'b1;
                        osr_data = fifo_data;
                        count_d  = '0;
                        state_d  = S_RUN;
                    end
                end

                S_PULL_WAIT: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        osr_load   = 1'b1;
                        osr_data   = fifo_data;
                        count_d    = '0;
                        instr_done = 1'b1;
                        state_d    = S_RUN;
                    end
                end

                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    assign stall = !rst && instr_valid && !instr_done;

endmodule

// File: tb/tb_osr_controller.sv
module tb_osr_controller;
    import osr_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    osr_op_t     instr_op;
    logic [4:0]  out_count;
    logic        pull_block;
    logic        pull_ifempty;
    logic [31:0] mov_data;
    logic [31:0] x_data;
    logic        autopull_en;
    logic [4:0]  pull_thresh;
    logic        sm_restart;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        osr_load;
    logic [31:0] osr_data;
    logic        osr_shift_en;
    logic [5:0]  osr_shift_count;
    logic        instr_done;
    logic        stall;
    logic [5:0]  osr_count;

    always #5 clk = ~clk;

    osr_controller dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_op(instr_op),
        .out_count(out_count), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
        .mov_data(mov_data), .x_data(x_data), .autopull_en(autopull_en),
        .pull_thresh(pull_thresh), .sm_restart(sm_restart), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop), .osr_load(osr_load),
        .osr_data(osr_data), .osr_shift_en(osr_shift_en),
        .osr_shift_count(osr_shift_count), .instr_done(instr_done), .stall(stall),
        .osr_count(osr_count)
    );

    typedef struct {
        string       tag;
        logic        pop;
        logic        load;
        logic [31:0] data;
        logic        sh_en;
        logic [5:0]  sh_cnt;
        logic        done;
        logic        stl;
        logic [5:0]  cnt_after;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    // Queue expected behaviour for the cycle about to run.
    task automatic expect_cyc(input string tag, input logic pop, input logic load,
                              input logic [31:0] data, input logic sh_en,
                              input logic [5:0] sh_cnt, input logic done,
                              input logic stl, input logic [5:0] cnt_after);
        exp_t e;
        e.tag = tag; e.pop = pop; e.load = load; e.data = data; e.sh_en = sh_en;
        e.sh_cnt = sh_cnt; e.done = done; e.stl = stl; e.cnt_after = cnt_after;
        exp_q.push_back(e);
    endtask

    // Run one clock: compare combinational outputs at negedge, count after posedge.
    task automatic step();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        @(negedge clk);
        chk({e.tag, ".pop"},   {31'd0, fifo_pop},     {31'd0, e.pop});
        chk({e.tag, ".load"},  {31'd0, osr_load},     {31'd0, e.load});
        if (e.load) chk({e.tag, ".data"}, osr_data, e.data);
        chk({e.tag, ".shen"},  {31'd0, osr_shift_en}, {31'd0, e.sh_en});
        if (e.sh_en) chk({e.tag, ".shcnt"}, {26'd0, osr_shift_count}, {26'd0, e.sh_cnt});
        chk({e.tag, ".done"},  {31'd0, instr_done},   {31'd0, e.done});
        chk({e.tag, ".stall"}, {31'd0, stall},        {31'd0, e.stl});
        @(posedge clk);
        #1;
        chk({e.tag, ".count"}, {26'd0, osr_count},    {26'd0, e.cnt_after});
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = OP_NONE; out_count = 5'd0;
        pull_block = 1'b0; pull_ifempty = 1'b0; mov_data = '0; x_data = '0;
        autopull_en = 1'b1; pull_thresh = 5'd0; sm_restart = 1'b0;
        fifo_empty = 1'b0; fifo_data = 32'hA5A5_0001;

        // Reset: outputs quiet even with FIFO data ready.
        expect_cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 6'd32); step();
        expect_cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 6'd32); step();

        // First idle cycle after reset refills (thr=32).
        rst = 1'b0;
        expect_cyc("bgfill", 1, 1, 32'hA5A5_0001, 0, 0, 0, 0, 6'd0); step();

        // thr=8, OUT 8 twice with FIFO non-empty.
        pull_thresh = 5'd8; fifo_data = 32'h1111_2222;
        instr_valid = 1'b1; instr_op = OP_OUT; out_count = 5'd8;
        expect_cyc("out8a", 0, 0, 0, 1, 6'd8, 1, 0, 6'd8); step();
        expect_cyc("out8b_pull", 1, 1, 32'h1111_2222, 0, 0, 0, 1, 6'd0); step();
        expect_cyc("out8b_shift", 0, 0, 0, 1, 6'd8, 1, 0, 6'd8); step();
        // Idle with empty FIFO at threshold: nothing happens.
        instr_valid = 1'b0; fifo_empty = 1'b1;
        expect_cyc("idle_empty", 0, 0, 0, 0, 0, 0, 0, 6'd8); step();

        // Autopull off: OUT 32 saturates, never stalls.
        autopull_en = 1'b0; instr_valid = 1'b1; instr_op = OP_OUT; out_count = 5'd0;
        expect_cyc("sat1", 0, 0, 0, 1, 6'd32, 1, 0, 6'd32); step();
        expect_cyc("sat2", 0, 0, 0, 1, 6'd32, 1, 0, 6'd32); step();

        // thr=32, count=32, FIFO empty: OUT waits for data.
        autopull_en = 1'b1; pull_thresh = 5'd0; out_count = 5'd4;
        expect_cyc("ow_stall0", 0, 0, 0, 0, 0, 0, 1, 6'd32); step();
        expect_cyc("ow_stall1", 0, 0, 0, 0, 0, 0, 1, 6'd32); step();
        fifo_empty = 1'b0; fifo_data = 32'h3333_4444;
        expect_cyc("ow_load", 1, 1, 32'h3333_4444, 0, 0, 0, 1, 6'd0); step();
        fifo_empty = 1'b1;
        expect_cyc("ow_shift", 0, 0, 0, 1, 6'd4, 1, 0, 6'd4); step();

        // Blocking PULL on empty FIFO for 3 cycles.
        instr_op = OP_PULL; pull_block = 1'b1;
        expect_cyc("pw0", 0, 0, 0, 0, 0, 0, 1, 6'd4); step();
        expect_cyc("pw1", 0, 0, 0, 0, 0, 0, 1, 6'd4); step();
        expect_cyc("pw2", 0, 0, 0, 0, 0, 0, 1, 6'd4); step();
        fifo_empty = 1'b0; fifo_data = 32'h5555_6666;
        expect_cyc("pw_done", 1, 1, 32'h5555_6666, 0, 0, 1, 0, 6'd0); step();
        // Non-blocking PULL on empty FIFO loads X.
        fifo_empty = 1'b1; pull_block = 1'b0; x_data = 32'h7777_8888;
        expect_cyc("pull_x", 0, 1, 32'h7777_8888, 0, 0, 1, 0, 6'd0); step();
        // PULL ifempty below threshold: no-op completion.
        pull_ifempty = 1'b1; fifo_empty = 1'b0; fifo_data = 32'h9999_AAAA;
        expect_cyc("pull_ifempty", 0, 0, 0, 0, 0, 1, 0, 6'd0); step();
        pull_ifempty = 1'b0;

        // MOV while background refill would be eligible.
        autopull_en = 1'b0; instr_op = OP_OUT; out_count = 5'd4;
        expect_cyc("pre_mov", 0, 0, 0, 1, 6'd4, 1, 0, 6'd4); step();
        autopull_en = 1'b1; pull_thresh = 5'd4;
        instr_op = OP_MOV; mov_data = 32'hDEAD_BEEF;
        expect_cyc("mov", 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 6'd0); step();

        // sm_restart while in S_OUT_WAIT.
        fifo_empty = 1'b1; instr_op = OP_OUT;
        expect_cyc("pre_rs", 0, 0, 0, 1, 6'd4, 1, 0, 6'd4); step();
        expect_cyc("rs_wait", 0, 0, 0, 0, 0, 0, 1, 6'd4); step();
        instr_valid = 1'b0; sm_restart = 1'b1; fifo_empty = 1'b0;
        expect_cyc("restart", 0, 0, 0, 0, 0, 0, 0, 6'd32); step();
        // Back in S_RUN: OUT with autopull off executes directly.
        sm_restart = 1'b0; fifo_empty = 1'b1; autopull_en = 1'b0;
        instr_valid = 1'b1; instr_op = OP_OUT; out_count = 5'd1;
        expect_cyc("rs_run", 0, 0, 0, 1, 6'd1, 1, 0, 6'd32); step();

        // Reset in the middle of a blocking PULL abandons it.
        instr_op = OP_PULL; pull_block = 1'b1;
        expect_cyc("rp_stall", 0, 0, 0, 0, 0, 0, 1, 6'd32); step();
        rst = 1'b1; fifo_empty = 1'b0; fifo_data = 32'hBBBB_CCCC;
        expect_cyc("rp_rst", 0, 0, 0, 0, 0, 0, 0, 6'd32); step();
        rst = 1'b0; instr_valid = 1'b0;
        expect_cyc("rp_idle", 0, 0, 0, 0, 0, 0, 0, 6'd32); step();
        instr_valid = 1'b1;
        expect_cyc("rp_pull", 1, 1, 32'hBBBB_CCCC, 0, 0, 1, 0, 6'd0); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
